// File: rtl/fp_cmd_issuer_if.sv
// Command, ALU operand/result and response signals of the FP command issuer.
// master = the issuer itself, slave = the environment (command source, ALU, consumer).
interface fp_cmd_issuer_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [1:0]       alu_op;
  logic             s_axis_a_tvalid;
  logic [31:0]      s_axis_a_tdata;
  logic             s_axis_b_tvalid;
  logic [31:0]      s_axis_b_tdata;
  logic             m_axis_result_tvalid;
  logic [31:0]      m_axis_result_tdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [1:0]       resp_op;
  logic             resp_timeout;
  logic [7:0]       stray_count;
  logic [CNT_W-1:0] done_count;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  m_axis_result_tvalid, m_axis_result_tdata,
    input  resp_ready,
    output cmd_ready, alu_op,
    output s_axis_a_tvalid, s_axis_a_tdata, s_axis_b_tvalid, s_axis_b_tdata,
    output resp_valid, resp_data, resp_op, resp_timeout,
    output stray_count, done_count
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output m_axis_result_tvalid, m_axis_result_tdata,
    output resp_ready,
    input  cmd_ready, alu_op,
    input  s_axis_a_tvalid, s_axis_a_tdata, s_axis_b_tvalid, s_axis_b_tdata,
    input  resp_valid, resp_data, resp_op, resp_timeout,
    input  stray_count, done_count
  );
endinterface

// File: rtl/fp_cmd_issuer.sv
// Issues one FP command to the ALU operand streams, waits for the result (or a timeout)
// and returns it on a valid/ready response port; one command in flight at a time.
module fp_cmd_issuer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  fp_cmd_issuer_if.master     bus
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           r_state;
  logic             r_cmd_ready;
  logic             r_tvalid;
  logic [1:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [TW-1:0]    r_timer;
  logic             r_resp_valid;
  logic [31:0]      r_resp_data;
  logic [1:0]       r_resp_op;
  logic             r_resp_timeout;
  logic [7:0]       r_stray;
  logic [CNT_W-1:0] r_done;

  logic w_result_in_wait;
  logic w_stray;
  logic w_timer_last;

  assign w_result_in_wait = bus.m_axis_result_tvalid && (r_state == S_WAIT);
  assign w_stray          = bus.m_axis_result_tvalid && (r_state != S_WAIT);
  assign w_timer_last     = (r_timer == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_cmd_ready    <= 1'b0;
      r_tvalid       <= 1'b0;
      r_op           <= 2'd0;
      r_a            <= 32'd0;
      r_b            <= 32'd0;
      r_timer        <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= 32'd0;
      r_resp_op      <= 2'd0;
      r_resp_timeout <= 1'b0;
      r_stray        <= 8'd0;
      r_done         <= '0;
    end else begin
      // Results outside WAIT belong to no command: count them, never latch them.
      if (w_stray && (r_stray != 8'hFF)) begin
        r_stray <= r_stray + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_op        <= bus.cmd_op;
            r_a         <= bus.cmd_a;
            r_b         <= bus.cmd_b;
            r_tvalid    <= 1'b1;
            r_state     <= S_ISSUE;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        S_ISSUE: begin
          r_tvalid <= 1'b0;
          r_timer  <= '0;
          r_state  <= S_WAIT;
        end

        S_WAIT: begin
          r_timer <= r_timer + TW'(1);
          // A result landing on the final timeout cycle still takes priority.
          if (w_result_in_wait) begin
            r_resp_data    <= bus.m_axis_result_tdata;
            r_resp_timeout <= 1'b0;
            r_resp_op      <= r_op;
            r_resp_valid   <= 1'b1;
            r_state        <= S_RESP;
          end else if (w_timer_last) begin
            r_resp_data    <= 32'h7FC0_0000;
            r_resp_timeout <= 1'b1;
            r_resp_op      <= r_op;
            r_resp_valid   <= 1'b1;
            r_state        <= S_RESP;
          end
        end

        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_done       <= r_done + CNT_W'(1);
            r_cmd_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready       = r_cmd_ready;
  assign bus.alu_op          = r_op;
  assign bus.s_axis_a_tvalid = r_tvalid;
  assign bus.s_axis_a_tdata  = r_a;
  assign bus.s_axis_b_tvalid = r_tvalid;
  assign bus.s_axis_b_tdata  = r_b;
  assign bus.resp_valid      = r_resp_valid;
  assign bus.resp_data       = r_resp_data;
  assign bus.resp_op         = r_resp_op;
  assign bus.resp_timeout    = r_resp_timeout;
  assign bus.stray_count     = r_stray;
  assign bus.done_count      = r_done;

endmodule

// File: tb/tb_fp_cmd_issuer.sv
// Directed bench for fp_cmd_issuer: inputs driven and outputs sampled on the falling edge,
// with a cycle-exact ALU stand-in that returns a fixed result L cycles after the operand pulse.
module tb_fp_cmd_issuer;

  logic i_clk;
  logic i_rst_n;
  int   n_vec;
  int   n_err;

  fp_cmd_issuer_if #(.CNT_W(16)) bus ();

  fp_cmd_issuer #(
    .TIMEOUT_CYC (64),
    .CNT_W       (16)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.master)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Cycle 0 = command accepted; lat = 0 means the ALU never answers.
  task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] rdata,
                         input int stall, input bit stray_in_stall,
                         input logic [31:0] exp_data, input bit exp_to,
                         input int exp_cyc, input logic [15:0] exp_done);
    int w;
    int cyc;
    bit got;
    w = 0;
    while (!bus.cmd_ready && w < 10) begin
      @(negedge i_clk);
      w++;
    end
    chk("cmd_ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(negedge i_clk);
    bus.cmd_valid = 1'b0;
    cyc = 1;
    chk("a_tvalid_cyc1", 32'(bus.s_axis_a_tvalid), 32'd1);
    chk("b_tvalid_cyc1", 32'(bus.s_axis_b_tvalid), 32'd1);
    chk("a_tdata", bus.s_axis_a_tdata, a);
    chk("b_tdata", bus.s_axis_b_tdata, b);
    chk("alu_op", 32'(bus.alu_op), 32'(op));
    chk("cmd_ready_issue", 32'(bus.cmd_ready), 32'd0);
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge i_clk);
      cyc++;
      bus.m_axis_result_tvalid = (lat > 0) && (cyc == 1 + lat);
      bus.m_axis_result_tdata  = (lat > 0 && cyc == 1 + lat) ? rdata : 32'h0BAD_0BAD;
      if (bus.resp_valid) got = 1'b1;
      if (cyc == 2) begin
        chk("a_tvalid_wait", 32'(bus.s_axis_a_tvalid), 32'd0);
        chk("a_tdata_held", bus.s_axis_a_tdata, a);
        chk("alu_op_held", 32'(bus.alu_op), 32'(op));
      end
    end
    bus.m_axis_result_tvalid = 1'b0;
    chk("resp_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("resp_valid_cycle", 32'(cyc), 32'(exp_cyc));
    chk("resp_data", bus.resp_data, exp_data);
    chk("resp_op", 32'(bus.resp_op), 32'(op));
    chk("resp_timeout", 32'(bus.resp_timeout), 32'(exp_to));
    chk("cmd_ready_resp", 32'(bus.cmd_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      bus.m_axis_result_tvalid = stray_in_stall;
      bus.m_axis_result_tdata  = 32'hDEAD_BEEF;
      @(negedge i_clk);
      chk("resp_valid_stall", 32'(bus.resp_valid), 32'd1);
      chk("resp_data_stall", bus.resp_data, exp_data);
      chk("cmd_ready_stall", 32'(bus.cmd_ready), 32'd0);
    end
    bus.m_axis_result_tvalid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge i_clk);
    bus.resp_ready = 1'b0;
    chk("resp_valid_after_handoff", 32'(bus.resp_valid), 32'd0);
    chk("done_count", 32'(bus.done_count), 32'(exp_done));
    chk("cmd_ready_after_handoff", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    i_rst_n                  = 1'b0;
    bus.cmd_valid            = 1'b0;
    bus.cmd_op               = 2'd0;
    bus.cmd_a                = 32'd0;
    bus.cmd_b                = 32'd0;
    bus.m_axis_result_tvalid = 1'b0;
    bus.m_axis_result_tdata  = 32'd0;
    bus.resp_ready           = 1'b0;

    repeat (3) @(negedge i_clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_a_tdata", bus.s_axis_a_tdata, 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_done_count", 32'(bus.done_count), 32'd0);
    chk("rst_stray_count", 32'(bus.stray_count), 32'd0);
    i_rst_n = 1'b1;
    #1;
    chk("cmd_ready_at_release", 32'(bus.cmd_ready), 32'd0);
    @(negedge i_clk);
    chk("cmd_ready_first_cycle", 32'(bus.cmd_ready), 32'd1);

    // T1: 3.0 + 1.5 = 4.5, L = 11 -> resp_valid at cycle 13
    run_txn(2'd0, 32'h4040_0000, 32'h3FC0_0000, 11, 32'h4090_0000, 0, 1'b0,
            32'h4090_0000, 1'b0, 13, 16'd1);
    chk("stray_after_t1", 32'(bus.stray_count), 32'd0);

    // T2: 1.0 / 0.0 = +inf, consumer stalls 5 cycles while strays hit RESP
    run_txn(2'd3, 32'h3F80_0000, 32'h0000_0000, 3, 32'h7F80_0000, 5, 1'b1,
            32'h7F80_0000, 1'b0, 5, 16'd2);
    chk("stray_after_t2", 32'(bus.stray_count), 32'd5);

    // T3: no ALU answer -> 64 WAIT cycles (2..65), timeout response at cycle 66
    run_txn(2'd2, 32'h4000_0000, 32'h4000_0000, 0, 32'd0, 0, 1'b0,
            32'h7FC0_0000, 1'b1, 66, 16'd3);

    // T4: result on the last timeout cycle (65) wins over the timeout
    run_txn(2'd1, 32'h4120_0000, 32'h3F80_0000, 64, 32'h4110_0000, 0, 1'b0,
            32'h4110_0000, 1'b0, 66, 16'd4);

    for (int k = 0; k < 95; k++) begin
      bus.m_axis_result_tvalid = 1'b1;
      bus.m_axis_result_tdata  = 32'h5555_AAAA;
      @(negedge i_clk);
      bus.m_axis_result_tvalid = 1'b0;
      @(negedge i_clk);
    end
    chk("stray_count_100", 32'(bus.stray_count), 32'd100);
    for (int k = 0; k < 205; k++) begin
      bus.m_axis_result_tvalid = 1'b1;
      @(negedge i_clk);
      bus.m_axis_result_tvalid = 1'b0;
      @(negedge i_clk);
    end
    chk("stray_count_sat", 32'(bus.stray_count), 32'd255);
    chk("resp_data_after_strays", bus.resp_data, 32'h4110_0000);
    chk("resp_valid_after_strays", 32'(bus.resp_valid), 32'd0);

    // T5: reset in WAIT aborts the command
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_a     = 32'h4080_0000;
    bus.cmd_b     = 32'h4080_0000;
    @(negedge i_clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("t5_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("t5_rst_a_tdata", bus.s_axis_a_tdata, 32'd0);
    chk("t5_rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("t5_rst_done", 32'(bus.done_count), 32'd0);
    chk("t5_rst_stray", 32'(bus.stray_count), 32'd0);
    chk("t5_rst_resp_data", bus.resp_data, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("t5_no_resp", 32'(bus.resp_valid), 32'd0);

    run_txn(2'd2, 32'h4000_0000, 32'h4040_0000, 2, 32'h40C0_0000, 0, 1'b0,
            32'h40C0_0000, 1'b0, 4, 16'd1);
    run_txn(2'd1, 32'h40A0_0000, 32'h3F80_0000, 5, 32'h4080_0000, 0, 1'b0,
            32'h4080_0000, 1'b0, 7, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
